// File: rtl/scalar_issue_pkg.sv
// rtl/scalar_issue_pkg.sv - shared types and constants for the scalar issue stage
package scalar_issue_pkg;

    localparam int NUM_SFU = 3;
    localparam int TAG_W   = 2;

    typedef logic [TAG_W-1:0] tag_t;

    localparam tag_t TAG_NONE = '0;

    typedef enum logic [1:0] {
        FU_ALU = 2'd0,
        FU_MUL = 2'd1,
        FU_DIV = 2'd2
    } fu_scalar_t;

    typedef struct packed {
        logic [3:0] op;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } fust_s_row_t;

    typedef struct packed {
        fust_s_row_t [NUM_SFU-1:0] row;
    } fust_s_t;

    typedef struct packed {
        logic [1:0]  fu;
        fust_s_row_t row;
    } issue_s_t;

endpackage

// File: rtl/scalar_issue_if.sv
// rtl/scalar_issue_if.sv - dispatch, writeback, FU-ready and issue signals of the scalar issue stage
interface scalar_issue_if;
    import scalar_issue_pkg::*;

    logic                disp_en;
    fu_scalar_t          disp_fu;
    tag_t                disp_t1;
    tag_t                disp_t2;
    fust_s_t             fust;
    logic                wb_valid;
    tag_t                wb_tag;
    logic [NUM_SFU-1:0]  fu_ready;
    logic                flush;
    logic [NUM_SFU-1:0]  busy;
    logic                issue_valid;
    issue_s_t            issue_pkt;

    modport master (
        output disp_en, disp_fu, disp_t1, disp_t2, fust, wb_valid, wb_tag, fu_ready, flush,
        input  busy, issue_valid, issue_pkt
    );

    modport slave (
        input  disp_en, disp_fu, disp_t1, disp_t2, fust, wb_valid, wb_tag, fu_ready, flush,
        output busy, issue_valid, issue_pkt
    );

endinterface

// File: rtl/sc_age_matrix.sv
// rtl/sc_age_matrix.sv - older-than matrix picking the oldest requesting row
module sc_age_matrix
    import scalar_issue_pkg::*;
(
    input  logic               clk,
    input  logic               clr_all,
    input  logic               set_young,
    input  logic [1:0]         set_idx,
    input  logic               clr,
    input  logic [1:0]         clr_idx,
    input  logic [NUM_SFU-1:0] req,
    output logic [NUM_SFU-1:0] oldest
);

    // older[i][j] set means row i was dispatched before row j
    logic [NUM_SFU-1:0] older [NUM_SFU];
    logic [NUM_SFU-1:0] blocked;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SFU; i++) begin
            for (int j = 0; j < NUM_SFU; j++) begin
                if (clr_all) begin
                    older[i][j] <= 1'b0;
                end else if (clr && (int'(clr_idx) == i || int'(clr_idx) == j)) begin
                    older[i][j] <= 1'b0;
                end else if (set_young && int'(set_idx) == i) begin
                    older[i][j] <= 1'b0;
                end else if (set_young && int'(set_idx) == j && i != j) begin
                    older[i][j] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        blocked = '0;
        oldest  = '0;
        for (int i = 0; i < NUM_SFU; i++) begin
            for (int j = 0; j < NUM_SFU; j++) begin
                if (j != i && req[j] && older[j][i]) begin
                    blocked[i] = 1'b1;
                end
            end
            oldest[i] = req[i] & ~blocked[i];
        end
    end

endmodule

// File: rtl/scalar_issue.sv
// rtl/scalar_issue.sv - scalar issue stage: operand wakeup, oldest-ready select, registered issue packet
module scalar_issue
    import scalar_issue_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    scalar_issue_if.slave  sif
);

    logic [NUM_SFU-1:0] busy_q;
    tag_t               t1q [NUM_SFU];
    tag_t               t2q [NUM_SFU];
    logic               issue_valid_q;
    issue_s_t           issue_pkt_q;

    logic [NUM_SFU-1:0] ready;
    logic [NUM_SFU-1:0] cand;
    logic [NUM_SFU-1:0] oldest;
    logic [1:0]         sel;
    logic               disp_ok;

    function automatic logic woken(tag_t t, logic v, tag_t w);
        return v && (w != TAG_NONE) && (t == w);
    endfunction

    // readiness includes wakeup by this cycle's writeback
    always_comb begin
        ready = '0;
        for (int i = 0; i < NUM_SFU; i++) begin
            ready[i] = busy_q[i]
                     & ((t1q[i] == TAG_NONE) | woken(t1q[i], sif.wb_valid, sif.wb_tag))
                     & ((t2q[i] == TAG_NONE) | woken(t2q[i], sif.wb_valid, sif.wb_tag));
        end
    end

    assign cand    = ready & sif.fu_ready;
    assign disp_ok = sif.disp_en && (int'(sif.disp_fu) < NUM_SFU);

    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_SFU; i++) begin
            if (oldest[i]) begin
                sel = 2'(i);
            end
        end
    end

    sc_age_matrix u_age (
        .clk       (clk),
        .clr_all   (rst | sif.flush),
        .set_young (disp_ok),
        .set_idx   (sif.disp_fu),
        .clr       (|cand),
        .clr_idx   (sel),
        .req       (cand),
        .oldest    (oldest)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q        <= '0;
            issue_valid_q <= 1'b0;
            issue_pkt_q   <= '0;
            for (int i = 0; i < NUM_SFU; i++) begin
                t1q[i] <= TAG_NONE;
                t2q[i] <= TAG_NONE;
            end
        end else if (sif.flush) begin
            busy_q        <= '0;
            issue_valid_q <= 1'b0;
            for (int i = 0; i < NUM_SFU; i++) begin
                t1q[i] <= TAG_NONE;
                t2q[i] <= TAG_NONE;
            end
        end else begin
            for (int i = 0; i < NUM_SFU; i++) begin
                if (woken(t1q[i], sif.wb_valid, sif.wb_tag)) t1q[i] <= TAG_NONE;
                if (woken(t2q[i], sif.wb_valid, sif.wb_tag)) t2q[i] <= TAG_NONE;
            end
            if (|cand) begin
                busy_q[sel]   <= 1'b0;
                issue_valid_q <= 1'b1;
                issue_pkt_q   <= '{fu: sel, row: sif.fust.row[sel]};
            end else begin
                issue_valid_q <= 1'b0;
            end
            // dispatch targets an idle row, so it never collides with the issuing row
            if (disp_ok) begin
                busy_q[sif.disp_fu] <= 1'b1;
                t1q[sif.disp_fu] <= woken(sif.disp_t1, sif.wb_valid, sif.wb_tag) ? TAG_NONE : sif.disp_t1;
                t2q[sif.disp_fu] <= woken(sif.disp_t2, sif.wb_valid, sif.wb_tag) ? TAG_NONE : sif.disp_t2;
            end
        end
    end

    assign sif.busy        = busy_q;
    assign sif.issue_valid = issue_valid_q;
    assign sif.issue_pkt   = issue_pkt_q;

endmodule

// File: tb/tb_scalar_issue.sv
// tb/tb_scalar_issue.sv - self-checking bench for scalar_issue with an in-order-list reference model
module tb_scalar_issue;
    import scalar_issue_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    bit   chk_en   = 1'b0;

    always #5 clk = ~clk;

    scalar_issue_if dif ();

    scalar_issue dut (
        .clk (clk),
        .rst (rst),
        .sif (dif)
    );

    fust_s_row_t row_a0, row_a1, row_a2, row_b0, row_b1, row_b2;

    // reference model: rows kept in dispatch order, oldest first
    bit       m_busy [3];
    int       m_t1   [3];
    int       m_t2   [3];
    int       order  [$];
    logic     exp_valid;
    issue_s_t exp_pkt;

    function automatic bit tag_ok(int t);
        return (t == 0) || (dif.wb_valid && int'(dif.wb_tag) != 0 && t == int'(dif.wb_tag));
    endfunction

    function automatic bit wb_hits(int t);
        return dif.wb_valid && int'(dif.wb_tag) != 0 && t == int'(dif.wb_tag);
    endfunction

    always @(posedge clk) begin : mdl
        int pick, kp, f;
        if (rst || dif.flush) begin
            for (int i = 0; i < 3; i++) begin
                m_busy[i] = 1'b0; m_t1[i] = 0; m_t2[i] = 0;
            end
            order.delete();
            exp_valid = 1'b0;
            if (rst) exp_pkt = '0;
        end else begin
            pick = -1; kp = -1;
            for (int k = 0; k < order.size(); k++) begin
                f = order[k];
                if (pick < 0 && m_busy[f] && dif.fu_ready[f] && tag_ok(m_t1[f]) && tag_ok(m_t2[f])) begin
                    pick = f; kp = k;
                end
            end
            for (int i = 0; i < 3; i++) begin
                if (wb_hits(m_t1[i])) m_t1[i] = 0;
                if (wb_hits(m_t2[i])) m_t2[i] = 0;
            end
            if (pick >= 0) begin
                m_busy[pick] = 1'b0;
                order.delete(kp);
                exp_valid    = 1'b1;
                exp_pkt.fu   = 2'(pick);
                exp_pkt.row  = dif.fust.row[pick];
            end else begin
                exp_valid = 1'b0;
            end
            f = int'(dif.disp_fu);
            if (dif.disp_en && f < 3) begin
                m_busy[f] = 1'b1;
                m_t1[f]   = wb_hits(int'(dif.disp_t1)) ? 0 : int'(dif.disp_t1);
                m_t2[f]   = wb_hits(int'(dif.disp_t2)) ? 0 : int'(dif.disp_t2);
                order.push_back(f);
            end
        end
    end

    always @(posedge clk) begin
        if (!rst && dif.disp_en)
            assert (!dif.busy[dif.disp_fu]) else $error("illegal dispatch to busy row %0d", dif.disp_fu);
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_busy", 32'(dif.busy), 32'({m_busy[2], m_busy[1], m_busy[0]}));
            chk("model_valid", 32'(dif.issue_valid), 32'(exp_valid));
            chk("model_pkt", 32'(dif.issue_pkt), 32'(exp_pkt));
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        dif.disp_en  = 1'b0;
        dif.disp_t1  = '0;
        dif.disp_t2  = '0;
        dif.wb_valid = 1'b0;
        dif.wb_tag   = '0;
        dif.flush    = 1'b0;
    endtask

    task automatic disp(fu_scalar_t f, tag_t a, tag_t b);
        dif.disp_en = 1'b1;
        dif.disp_fu = f;
        dif.disp_t1 = a;
        dif.disp_t2 = b;
    endtask

    task automatic scen1(string tag);
        dif.fu_ready = 3'b111;
        disp(FU_ALU, 2'd0, 2'd0);
        cyc();
        chk({tag, "_busy_c1"}, 32'(dif.busy), 32'b001);
        chk({tag, "_valid_c1"}, 32'(dif.issue_valid), 32'd0);
        idle();
        cyc();
        chk({tag, "_valid_c2"}, 32'(dif.issue_valid), 32'd1);
        chk({tag, "_pkt_c2"}, 32'(dif.issue_pkt), 32'({2'd0, row_a0}));
        chk({tag, "_busy_c2"}, 32'(dif.busy), 32'b000);
        cyc();
        chk({tag, "_valid_c3"}, 32'(dif.issue_valid), 32'd0);
    endtask

    initial begin
        row_a0 = '{op: 4'h1, rd: 5'd3,  rs1: 5'd4,  rs2: 5'd5};
        row_a1 = '{op: 4'h2, rd: 5'd6,  rs1: 5'd7,  rs2: 5'd8};
        row_a2 = '{op: 4'h3, rd: 5'd9,  rs1: 5'd10, rs2: 5'd11};
        row_b0 = '{op: 4'ha, rd: 5'd17, rs1: 5'd18, rs2: 5'd19};
        row_b1 = '{op: 4'hb, rd: 5'd20, rs1: 5'd21, rs2: 5'd22};
        row_b2 = '{op: 4'hc, rd: 5'd23, rs1: 5'd24, rs2: 5'd25};
        rst = 1'b1;
        idle();
        dif.disp_fu  = FU_ALU;
        dif.fu_ready = 3'b000;
        dif.fust.row[0] = row_a0;
        dif.fust.row[1] = row_a1;
        dif.fust.row[2] = row_a2;
        @(negedge clk);
        cyc();
        chk_en = 1'b1;
        chk("rst_busy", 32'(dif.busy), 32'd0);
        chk("rst_valid", 32'(dif.issue_valid), 32'd0);
        chk("rst_pkt", 32'(dif.issue_pkt), 32'd0);
        rst = 1'b0;
        cyc();

        scen1("s1");

        // operand waits on FU0 writeback
        disp(FU_MUL, 2'd1, 2'd0);
        cyc();
        idle();
        cyc();
        cyc();
        chk("s2_wait_busy", 32'(dif.busy), 32'b010);
        chk("s2_wait_valid", 32'(dif.issue_valid), 32'd0);
        dif.wb_valid = 1'b1;
        dif.wb_tag   = 2'd1;
        cyc();
        idle();
        chk("s2_valid", 32'(dif.issue_valid), 32'd1);
        chk("s2_pkt", 32'(dif.issue_pkt), 32'({2'd1, row_a1}));
        chk("s2_busy", 32'(dif.busy), 32'b000);
        cyc();

        // age order wins once FUs accept
        dif.fu_ready = 3'b000;
        disp(FU_DIV, 2'd0, 2'd0);
        cyc();
        disp(FU_ALU, 2'd0, 2'd0);
        cyc();
        idle();
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("s3_hold_busy", 32'(dif.busy), 32'b101);
            chk("s3_hold_valid", 32'(dif.issue_valid), 32'd0);
        end
        dif.fu_ready = 3'b111;
        cyc();
        chk("s3_first", 32'(dif.issue_pkt), 32'({2'd2, row_a2}));
        chk("s3_first_busy", 32'(dif.busy), 32'b001);
        cyc();
        chk("s3_second", 32'(dif.issue_pkt), 32'({2'd0, row_a0}));
        chk("s3_second_valid", 32'(dif.issue_valid), 32'd1);
        cyc();
        chk("s3_after", 32'(dif.issue_valid), 32'd0);

        // same-cycle bypass of rs2 tag
        dif.fust.row[0] = row_b0;
        dif.fust.row[1] = row_b1;
        dif.fust.row[2] = row_b2;
        disp(FU_MUL, 2'd0, 2'd2);
        dif.wb_valid = 1'b1;
        dif.wb_tag   = 2'd2;
        cyc();
        idle();
        chk("s4_busy", 32'(dif.busy), 32'b010);
        cyc();
        chk("s4_valid", 32'(dif.issue_valid), 32'd1);
        chk("s4_pkt", 32'(dif.issue_pkt), 32'({2'd1, row_b1}));
        cyc();

        // flush with concurrent dispatch
        dif.fu_ready = 3'b000;
        disp(FU_ALU, 2'd0, 2'd0);
        cyc();
        disp(FU_MUL, 2'd0, 2'd0);
        cyc();
        chk("s5_pre_busy", 32'(dif.busy), 32'b011);
        disp(FU_DIV, 2'd0, 2'd0);
        dif.flush = 1'b1;
        cyc();
        idle();
        chk("s5_busy", 32'(dif.busy), 32'b000);
        chk("s5_valid", 32'(dif.issue_valid), 32'd0);
        dif.fu_ready = 3'b111;
        cyc();
        chk("s5_dropped", 32'(dif.issue_valid), 32'd0);

        // reset while an issue is in flight and rows are busy
        disp(FU_ALU, 2'd2, 2'd0);
        cyc();
        disp(FU_DIV, 2'd2, 2'd0);
        cyc();
        disp(FU_MUL, 2'd0, 2'd0);
        cyc();
        idle();
        cyc();
        chk("s6_pre_busy", 32'(dif.busy), 32'b101);
        chk("s6_pre_valid", 32'(dif.issue_valid), 32'd1);
        chk("s6_pre_pkt", 32'(dif.issue_pkt), 32'({2'd1, row_b1}));
        rst = 1'b1;
        cyc();
        chk("s6_busy", 32'(dif.busy), 32'd0);
        chk("s6_valid", 32'(dif.issue_valid), 32'd0);
        chk("s6_pkt", 32'(dif.issue_pkt), 32'd0);
        rst = 1'b0;
        dif.fust.row[0] = row_a0;
        dif.fust.row[1] = row_a1;
        dif.fust.row[2] = row_a2;
        cyc();
        scen1("s6_post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
